// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: the global pipe_state_t control used by every pipeline latch.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PIPE_NORMAL = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_FLUSH  = 2'd2
    } pipe_state_t;

    // Only PIPE_NORMAL moves words; any undefined encoding behaves as a stall.
    function automatic logic pipe_is_normal(input pipe_state_t s);
        return (s == PIPE_NORMAL);
    endfunction

    // Flush clears the valid bits; undefined encodings never flush.
    function automatic logic pipe_is_flush(input pipe_state_t s);
        return (s == PIPE_FLUSH);
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Valid/ready/data handshake bundle used on both ends of pipe_stage_chain.
interface pipe_stage_chain_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // Producer side of a handshake.
    modport master (
        output valid,
        output data,
        input  ready
    );

    // Consumer side of a handshake.
    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage.sv
// One valid+data pipeline register with load and clear controls.
// clear wins over load; clear drops only the valid bit, the payload is don't-care.
module pipe_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             v_d;
    logic             v_q;
    logic [WIDTH-1:0] d_d;
    logic [WIDTH-1:0] d_q;

    // Next-state: hold by default, clear on flush, capture upstream on load.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clear) begin
            v_d = 1'b0;
        end else if (load) begin
            v_d = v_in;
            d_d = d_in;
        end
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign valid = v_q;
    assign data  = d_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH valid/data stages with valid/ready at both ends,
// bubble collapsing and global stall/flush control.
// Optional build macro: PIPE_STATS_EN enables the occupancy and stall_cnt
// statistics; without it both ports are tied to zero.
module pipe_stage_chain
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  pipe_state_t                  state,
    pipe_stage_chain_if.slave            up,
    pipe_stage_chain_if.master           dn,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [31:0]                  stall_cnt
);

    localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W   = 32;

    logic [DEPTH-1:0] stage_v;
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [DEPTH-1:0] rdy_c;
    logic [DEPTH-1:0] load_c;
    logic             normal_c;
    logic             flush_c;

    assign normal_c = pipe_is_normal(state);
    assign flush_c  = pipe_is_flush(state);

    // Ready chain from the output back to the input: a stage is ready when
    // it is empty or its word advances, so words fill any downstream bubble.
    always_comb begin : p_ready
        logic adv_up;
        rdy_c  = '0;
        adv_up = dn.ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            rdy_c[i] = !stage_v[i] || adv_up;
            adv_up   = src_v[i] && rdy_c[i];
        end
    end

    // Stages only move in normal operation; stall and undefined states hold.
    always_comb begin
        load_c = '0;
        if (normal_c) begin
            load_c = rdy_c;
        end
    end

    assign up.ready = normal_c && rdy_c[0];
    assign dn.valid = normal_c && stage_v[DEPTH-1];
    assign dn.data  = stage_d[DEPTH-1];

    for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_stage
        // Each stage is fed by its predecessor, stage 0 by the upstream port.
        if (gi == 0) begin : g_head
            assign src_v[gi] = up.valid;
            assign src_d[gi] = up.data;
        end else begin : g_body
            assign src_v[gi] = stage_v[gi-1];
            assign src_d[gi] = stage_d[gi-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (CLK),
            .rst_n (nRST),
            .load  (load_c[gi]),
            .clear (flush_c),
            .v_in  (src_v[gi]),
            .d_in  (src_d[gi]),
            .valid (stage_v[gi]),
            .data  (stage_d[gi])
        );
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    // Count cycles where upstream offers a word the chain cannot take; saturate.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (up.valid && !up.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Blocked-cycle counter register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign occupancy = OCC_W'($countones(stage_v));
`else
    assign stall_cnt = '0;
    assign occupancy = '0;
`endif

endmodule
